load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit that sits between the CPU execute/memory stage and the word-organised data memory, acting as the initiator on the memory port. It accepts one byte/halfword/word load or store request at a time, drives word-aligned memory read and write strobes, and performs read-modify-write for sub-word stores. Loaded data is extracted and sign- or zero-extended before it is returned to the pipeline, which stalls on `lsuBusy`.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data/word width; fixed at 32 for RV32.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `lsuStart`  in  1  request strobe; sampled only when `lsuBusy`=0.
- `lsuWrite`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32 width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- `addr`  in  32  byte address.
- `storeData`  in  32  store source (rs2).
- `lsuBusy`  out  1  high from accept through the DONE cycle.
- `lsuDone`  out  1  one-cycle completion pulse.
- `lsuError`  out  1  valid with `lsuDone`: misaligned or illegal `funct3`.
- `loadData`  out  32  extended load result; valid with `lsuDone`, held until next accept.
- `memAddr`  out  32  word-aligned address `{addr_r[31:2],2'b00}`.
- `memReadEnable`  out  1  read strobe.
- `memReadData`  in  32  combinational read word from memory.
- `memWriteEnable`  out  1  write strobe; exactly one cycle per store.
- `memWriteData`  out  32  full merged word.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE and `lsuStart`=1: register `lsuWrite`, `funct3`, `addr`, `storeData`. Check the request:
  - misaligned: half at `addr[0]`=1, word at `addr[1:0]`≠0;
  - illegal: loads with `funct3` 3/6/7, stores with `funct3` ≥3.
- Next state from IDLE:
  - error → DONE with `lsuError`=1; no memory strobe is issued.
  - load → READ.
  - SW → WRITE.
  - SB/SH → READ.
- READ: `memReadEnable`=1 and `memReadData` is captured at the edge. Load → DONE; SB/SH → WRITE.
- WRITE: `memWriteEnable`=1. `memWriteData` is one of:
  - the `storeData` word (SW);
  - the captured word with byte lane `addr[1:0]` replaced by `storeData[7:0]` (SB);
  - the captured word with halfword `addr[1]` replaced by `storeData[15:0]` (SH).
  - Then → DONE.
- DONE: `lsuDone`=1, then → IDLE unconditionally. `loadData` is the selected lane: sign-extended for LB/LH, zero-extended for LBU/LHU, the whole word for LW.
- `lsuStart` while busy is ignored; it is not queued.
- `memAddr`, `memWriteData` = 0 in IDLE. Both strobes are 0 outside READ/WRITE. The two strobes are never high together.

## Timing
- Reset: state IDLE; `lsuBusy`, `lsuDone`, `lsuError`, `memReadEnable`, `memWriteEnable` = 0; `loadData`, `memAddr`, `memWriteData` = 0.
- Cycles from accept edge to `lsuDone`:
  - load: 2 (READ, DONE);
  - SW: 2 (WRITE, DONE);
  - SB/SH: 3 (READ, WRITE, DONE);
  - error: 1.
- Back-to-back: the next request is accepted in the IDLE cycle after DONE. Minimum issue interval is 3 cycles (4 for SB/SH).
- Reset asserted in any state → IDLE at that edge. In the following cycle no strobe and no `lsuDone` are asserted, and a pending RMW write is dropped.
- `memAddr` and `memWriteData` are stable for the whole WRITE cycle, because memory writes are level-sensitive on `memWriteEnable`.

## Structure
- Package `lsu_pkg`:
  - `funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - state enum;
  - misalignment/legality function.
- Sub-module `lsu_align` (combinational): load-lane extraction/extension and store-lane merge, given `funct3`, `addr[1:0]`, word, `storeData`.
- Top level holds only the FSM and its registers.

## Test plan
- Memory word 0x100 = 0x8899AABB:
  - LB 0x101 → `loadData` 0xFFFFFFAA;
  - LBU 0x101 → 0x000000AA;
  - LH 0x102 → 0xFFFF8899;
  - each with `lsuDone` 2 cycles after accept.
- SB 0x102, `storeData` 0x12345677 → one READ cycle, one WRITE cycle with `memWriteData` 0x8877AABB, `memAddr` 0x100; `lsuDone` at cycle 3.
- SH 0x100, `storeData` 0x0000CAFE → word becomes 0x8899CAFE; a following LW 0x100 returns 0x8899CAFE.
- SW 0x104, 0xDEADBEEF → `memReadEnable` never high; a single WRITE cycle; `lsuDone` at cycle 2.
- Error cases:
  - LW 0x102 → `lsuDone`+`lsuError` 1 cycle after accept, no strobes;
  - SH 0x101 → same response;
  - load with `funct3`=3 → `lsuError`=1.
- Reset during READ of SB 0x100 → no `memWriteEnable` ever asserted, memory unchanged, `lsuBusy`=0 next cycle.
- `lsuStart` pulses while busy are ignored: exactly one `lsuDone` per accepted request.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32 funct3 width codes for loads and stores
//   - FSM state encoding
//   - lsu_req_error(): flags misaligned or illegal requests
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_e;

    // A request is rejected when the width code is not legal for its
    // direction (stores have no unsigned variants) or when the address is
    // not naturally aligned to the access size.
    function automatic logic lsu_req_error(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        case (f3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = is_store;
            default:          illegal = 1'b1;
        endcase
        case (f3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Ports:
//   funct3_i     width code of the request
//   addr_lo_i    byte offset within the word
//   word_i       word read from memory
//   store_data_i store source operand
//   load_data_o  selected lane, sign/zero extended (whole word for LW)
//   merged_o     word_i with the store lane replaced (store_data_i for SW)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'd0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'd0, half_sel};
            default: load_data_o = word_i;
        endcase

        merged_o = store_data_i;
        case (funct3_i)
            F3_B: begin
                merged_o = word_i;
                case (addr_lo_i)
                    2'd0:    merged_o[7:0]   = store_data_i[7:0];
                    2'd1:    merged_o[15:8]  = store_data_i[7:0];
                    2'd2:    merged_o[23:16] = store_data_i[7:0];
                    default: merged_o[31:24] = store_data_i[7:0];
                endcase
            end
            F3_H: begin
                merged_o = word_i;
                if (addr_lo_i[1]) merged_o[31:16] = store_data_i[15:0];
                else              merged_o[15:0]  = store_data_i[15:0];
            end
            default: merged_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store engine between the pipeline
// and a word-organised data memory. Sub-word stores use read-modify-write.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   lsuStart/lsuWrite/funct3/
//   addr/storeData               request (sampled only while lsuBusy=0)
//   lsuBusy/lsuDone/lsuError/
//   loadData                     pipeline response
//   memAddr/memReadEnable/
//   memReadData/memWriteEnable/
//   memWriteData                 word-aligned memory port
//   dbgState                     current FSM state (lsu_state_e encoding)
//
// Handshake: a request is taken on a rising edge where lsuStart=1 and
// lsuBusy=0; lsuBusy then stays high until the end of the single cycle in
// which lsuDone pulses (with lsuError/loadData valid). lsuStart while busy
// is dropped, never queued.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsuStart,
    input  logic              lsuWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] storeData,
    output logic              lsuBusy,
    output logic              lsuDone,
    output logic              lsuError,
    output logic [DATA_W-1:0] loadData,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memReadEnable,
    input  logic [DATA_W-1:0] memReadData,
    output logic              memWriteEnable,
    output logic [DATA_W-1:0] memWriteData,
    output logic [1:0]        dbgState
);

    lsu_state_e        state_q;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [DATA_W-1:0] store_q;

    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] load_q;
    logic [ADDR_W-1:0] maddr_q;
    logic              re_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] load_ext_d;
    logic [DATA_W-1:0] merge_word_d;

    // Lane logic works on the live read word so the READ edge can both
    // capture the load result and build the RMW word in one step.
    lsu_align u_align (
        .funct3_i     (funct3_q),
        .addr_lo_i    (addr_lo_q),
        .word_i       (memReadData),
        .store_data_i (store_q),
        .load_data_o  (load_ext_d),
        .merged_o     (merge_word_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            store_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            load_q    <= '0;
            maddr_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    re_q <= 1'b0;
                    we_q <= 1'b0;
                    if (lsuStart) begin
                        write_q   <= lsuWrite;
                        funct3_q  <= funct3;
                        addr_lo_q <= addr[1:0];
                        store_q   <= storeData;
                        busy_q    <= 1'b1;
                        load_q    <= '0;
                        maddr_q   <= {addr[ADDR_W-1:2], 2'b00};
                        if (lsu_req_error(lsuWrite, funct3, addr[1:0])) begin
                            // Rejected requests answer immediately, no strobe.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (lsuWrite && funct3 == F3_W) begin
                            // Full-word store needs no read.
                            state_q <= ST_WRITE;
                            we_q    <= 1'b1;
                            wdata_q <= storeData;
                        end else begin
                            state_q <= ST_READ;
                            re_q    <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    re_q <= 1'b0;
                    if (write_q) begin
                        state_q <= ST_WRITE;
                        we_q    <= 1'b1;
                        wdata_q <= merge_word_d;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        load_q  <= load_ext_d;
                    end
                end
                ST_WRITE: begin
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    maddr_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lsuBusy        = busy_q;
    assign lsuDone        = done_q;
    assign lsuError       = err_q;
    assign loadData       = load_q;
    assign memAddr        = maddr_q;
    assign memReadEnable  = re_q;
    assign memWriteEnable = we_q;
    assign memWriteData   = wdata_q;
    assign dbgState       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsuStart;
  logic        lsuWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        lsuBusy;
  logic        lsuDone;
  logic        lsuError;
  logic [31:0] loadData;
  logic [31:0] memAddr;
  logic        memReadEnable;
  logic [31:0] memReadData;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [1:0]  dbgState;

  // clock / reset block
  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .lsuStart       (lsuStart),
    .lsuWrite       (lsuWrite),
    .funct3         (funct3),
    .addr           (addr),
    .storeData      (storeData),
    .lsuBusy        (lsuBusy),
    .lsuDone        (lsuDone),
    .lsuError       (lsuError),
    .loadData       (loadData),
    .memAddr        (memAddr),
    .memReadEnable  (memReadEnable),
    .memReadData    (memReadData),
    .memWriteEnable (memWriteEnable),
    .memWriteData   (memWriteData),
    .dbgState       (dbgState)
  );

  // data memory seen by the DUT, and the model's view of what it must hold
  logic [31:0] mem [0:255];
  logic [31:0] shadow [0:255];

  assign memReadData = mem[memAddr[9:2]];

  always @(posedge clk) begin
    if (memWriteEnable) mem[memAddr[9:2]] <= memWriteData;
  end

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;
  int wr_seen = 0;
  int exp_done = 0;
  int exp_wr = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // behavioural model
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((a % size_of(f3)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    int sz;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    sz = size_of(f3);
    off = int'(a[1:0]);
    v = word >> (8 * off);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = v & mask;
    if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] sd, input logic [31:0] word);
    logic [7:0] b [4];
    logic [31:0] r;
    int sz;
    int off;
    sz = size_of(f3);
    off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) b[i] = word[8 * i +: 8];
    for (int i = 0; i < sz; i++) b[off + i] = sd[8 * i +: 8];
    r = {b[3], b[2], b[1], b[0]};
    return r;
  endfunction

  // cycle-by-cycle properties that hold regardless of the request
  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_overlap", {31'd0, memReadEnable & memWriteEnable}, 32'd0);
      if (!lsuBusy) begin
        check("idle_mem_addr", memAddr, 32'd0);
        check("idle_wdata", memWriteData, 32'd0);
        check("idle_strobes_done", {29'd0, memReadEnable, memWriteEnable, lsuDone}, 32'd0);
      end
      if (memWriteEnable) wr_seen++;
      if (lsuDone) done_seen++;
    end
  end

  // driver task: issues one request and checks its whole response
  task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input bit pulse, output logic [31:0] ld);
    bit e;
    bit got;
    int exp_lat;
    int reads;
    int writes;
    int idx;
    logic [31:0] old_word;
    logic [31:0] new_word;
    e = model_err(w, f3, a);
    exp_lat = e ? 1 : (!w ? 2 : (f3 == 3'd2 ? 2 : 3));
    idx = int'(a[9:2]);
    old_word = shadow[idx];
    new_word = (w && !e) ? model_store(f3, a, sd, old_word) : old_word;
    reads = 0;
    writes = 0;
    got = 1'b0;
    ld = 32'd0;
    @(negedge clk);
    check("busy_before_start", {31'd0, lsuBusy}, 32'd0);
    lsuStart = 1'b1;
    lsuWrite = w;
    funct3 = f3;
    addr = a;
    storeData = sd;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      lsuStart = pulse;
      check("busy", {31'd0, lsuBusy}, 32'd1);
      if (memReadEnable) begin
        reads++;
        check("read_addr", memAddr, {a[31:2], 2'b00});
      end
      if (memWriteEnable) begin
        writes++;
        check("write_addr", memAddr, {a[31:2], 2'b00});
        check("write_data", memWriteData, new_word);
      end
      if (lsuDone) begin
        got = 1'b1;
        lsuStart = 1'b0;
        check("done_latency", c, exp_lat);
        check("error", {31'd0, lsuError}, {31'd0, e});
        if (!w && !e) check("load_data", loadData, model_load(f3, a, old_word));
        ld = loadData;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      lsuStart = 1'b0;
      $display("FAIL done_timeout: no lsuDone within 8 cycles for addr 0x%08h", a);
    end
    check("read_cycles", reads, (!e && (!w || f3 != 3'd2)) ? 32'd1 : 32'd0);
    check("write_cycles", writes, (w && !e) ? 32'd1 : 32'd0);
    check("mem_word", mem[idx], new_word);
    shadow[idx] = new_word;
    exp_done++;
    if (w && !e) exp_wr++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] ld;
    for (int i = 0; i < 256; i++) mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    mem[64] = 32'h8899_AABB;
    mem[65] = 32'h0BAD_F00D;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];

    reset = 1'b1;
    lsuStart = 1'b0;
    lsuWrite = 1'b0;
    funct3 = 3'd0;
    addr = 32'd0;
    storeData = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy_done_err", {29'd0, lsuBusy, lsuDone, lsuError}, 32'd0);
    check("rst_strobes", {30'd0, memReadEnable, memWriteEnable}, 32'd0);
    check("rst_load_data", loadData, 32'd0);
    check("rst_mem_addr", memAddr, 32'd0);
    check("rst_wdata", memWriteData, 32'd0);
    mon_en = 1'b1;

    // loads from 0x8899AABB
    do_req(1'b0, 3'd0, 32'h101, 32'd0, 1'b0, ld); check("lb_0x101", ld, 32'hFFFF_FFAA);
    do_req(1'b0, 3'd4, 32'h101, 32'd0, 1'b0, ld); check("lbu_0x101", ld, 32'h0000_00AA);
    do_req(1'b0, 3'd1, 32'h102, 32'd0, 1'b0, ld); check("lh_0x102", ld, 32'hFFFF_8899);
    do_req(1'b0, 3'd5, 32'h102, 32'd0, 1'b0, ld); check("lhu_0x102", ld, 32'h0000_8899);
    do_req(1'b0, 3'd2, 32'h100, 32'd0, 1'b0, ld); check("lw_0x100", ld, 32'h8899_AABB);

    // stores
    do_req(1'b1, 3'd0, 32'h102, 32'h1234_5677, 1'b0, ld);
    check("sb_0x102_word", mem[64], 32'h8877_AABB);
    do_req(1'b1, 3'd2, 32'h100, 32'h8899_AABB, 1'b0, ld);
    do_req(1'b1, 3'd1, 32'h100, 32'h0000_CAFE, 1'b0, ld);
    do_req(1'b0, 3'd2, 32'h100, 32'd0, 1'b0, ld); check("lw_after_sh", ld, 32'h8899_CAFE);
    do_req(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 1'b0, ld);
    check("sw_0x104_word", mem[65], 32'hDEAD_BEEF);
    do_req(1'b0, 3'd0, 32'h107, 32'd0, 1'b0, ld); check("lb_0x107", ld, 32'hFFFF_FFDE);
    do_req(1'b0, 3'd4, 32'h104, 32'd0, 1'b0, ld); check("lbu_0x104", ld, 32'h0000_00EF);
    do_req(1'b0, 3'd1, 32'h106, 32'd0, 1'b0, ld); check("lh_0x106", ld, 32'hFFFF_DEAD);

    // rejected requests
    do_req(1'b0, 3'd2, 32'h102, 32'd0, 1'b0, ld);
    do_req(1'b1, 3'd1, 32'h101, 32'h0000_1111, 1'b0, ld);
    do_req(1'b0, 3'd3, 32'h100, 32'd0, 1'b0, ld);
    do_req(1'b1, 3'd4, 32'h100, 32'h0000_2222, 1'b0, ld);
    do_req(1'b0, 3'd5, 32'h103, 32'd0, 1'b0, ld);
    do_req(1'b0, 3'd6, 32'h104, 32'd0, 1'b0, ld);

    // lsuStart held high while busy must not start extra requests
    do_req(1'b0, 3'd2, 32'h104, 32'd0, 1'b1, ld); check("lw_pulsed", ld, 32'hDEAD_BEEF);
    do_req(1'b1, 3'd0, 32'h105, 32'h0000_00AB, 1'b1, ld);
    check("sb_pulsed_word", mem[65], 32'hDEAD_ABEF);

    // reset in the READ cycle of a byte store drops the write
    @(negedge clk);
    lsuStart = 1'b1;
    lsuWrite = 1'b1;
    funct3 = 3'd0;
    addr = 32'h100;
    storeData = 32'h0000_0055;
    @(negedge clk);
    lsuStart = 1'b0;
    check("rst_mid_read_strobe", {31'd0, memReadEnable}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, lsuBusy}, 32'd0);
    check("rst_mid_strobes_done", {29'd0, memReadEnable, memWriteEnable, lsuDone}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_write", {31'd0, memWriteEnable}, 32'd0);
    end
    check("rst_mid_mem", mem[64], 32'h8899_CAFE);

    do_req(1'b0, 3'd2, 32'h100, 32'd0, 1'b0, ld); check("lw_after_reset", ld, 32'h8899_CAFE);

    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    check("done_pulse_count", done_seen, exp_done);
    check("write_cycle_count", wr_seen, exp_wr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
